// File: rtl/pwm_demod.sv
// pwm_demod: PWM duty-cycle demodulator, duty = floor(H * 2^M / P) per measured period.
// Latency: duty_valid is M+1 cycles after the rise on pwm_s (+2 cycles on pwm_in with PWM_DEMOD_SYNC_EN).
// Backpressure: none; a rise that arrives while the divider is busy drops its capture and pulses ovr.
//
// Ports:
//   clk         system clock, all logic on posedge
//   rst         asynchronous, active-high reset
//   pwm_in      PWM stream to measure
//   duty        last recovered duty fraction, held between updates
//   duty_valid  1-cycle pulse when duty updates
//   ovr         1-cycle pulse when a capture is dropped because the divider is busy
//
// Build option: define PWM_DEMOD_SYNC_EN to pass pwm_in through a 2-flop
// synchronizer (for asynchronous/external sources). Results are identical in
// both builds; only the pwm_in -> duty_valid latency grows by 2 cycles.
module pwm_demod #(
    parameter int N = 14,   // counter width, max measurable period 2^N-1 cycles
    parameter int M = 12    // duty width and number of divider iterations
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pwm_in,
    output logic [M-1:0] duty,
    output logic         duty_valid,
    output logic         ovr
);

    localparam int ITW = $clog2(M + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_MEASURE = 2'd1;
    localparam logic [1:0] S_DIVIDE  = 2'd2;

    localparam logic [N-1:0]   CNT_MAX   = {N{1'b1}};
    localparam logic [N-1:0]   CNT_ONE   = N'(1);
    localparam logic [ITW-1:0] ITER_ONE  = ITW'(1);
    localparam logic [ITW-1:0] ITER_LAST = ITW'(M - 1);
    localparam logic [ITW-1:0] ITER_DONE = ITW'(M);

    // ------------------------------------------------------------------
    // Input path
    // ------------------------------------------------------------------
    logic pwm_s;
    logic pwm_d;
    logic rise;

`ifdef PWM_DEMOD_SYNC_EN
    logic [1:0] sync_ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_ff <= 2'b00;
        end else begin
            sync_ff <= {sync_ff[0], pwm_in};
        end
    end

    assign pwm_s = sync_ff[1];
`else
    assign pwm_s = pwm_in;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_d <= 1'b0;
        end else begin
            pwm_d <= pwm_s;
        end
    end

    assign rise = pwm_s & ~pwm_d;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]     state;
    logic [N-1:0]   per_cnt;
    logic [N-1:0]   hi_cnt;
    logic [N-1:0]   p_reg;
    // The remainder is always < P between iterations, so N bits hold it;
    // only the shifted value needs the extra bit.
    logic [N-1:0]   rem;
    // Only M-1 quotient bits are stored: the last bit goes straight to duty.
    logic [M-2:0]   quo;
    logic [ITW-1:0] iter;

    // Saturating counter increments
    logic [N-1:0] per_inc;
    logic [N-1:0] hi_inc;
    logic         timeout;
    logic [M-1:0] timeout_duty;

    assign per_inc      = (per_cnt == CNT_MAX) ? per_cnt : per_cnt + CNT_ONE;
    assign hi_inc       = (pwm_s && (hi_cnt != CNT_MAX)) ? hi_cnt + CNT_ONE : hi_cnt;
    // A rise in the same cycle wins: it is a real edge, so no timeout.
    assign timeout      = (per_cnt == CNT_MAX) && !rise;
    assign timeout_duty = pwm_s ? {M{1'b1}} : {M{1'b0}};

    // One restoring-divide step
    logic [N:0]   rem_sh;
    logic         qbit;
    logic [N:0]   rem_sub;
    logic [N-1:0] rem_nxt;
    logic [M-1:0] quo_nxt;

    always_comb begin
        rem_sh  = {rem, 1'b0};
        qbit    = (rem_sh >= {1'b0, p_reg});
        rem_sub = rem_sh - {1'b0, p_reg};
        rem_nxt = qbit ? rem_sub[N-1:0] : rem_sh[N-1:0];
        quo_nxt = {quo, qbit};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            per_cnt    <= '0;
            hi_cnt     <= '0;
            p_reg      <= '0;
            rem        <= '0;
            quo        <= '0;
            iter       <= '0;
            duty       <= '0;
            duty_valid <= 1'b0;
            ovr        <= 1'b0;
        end else begin
            duty_valid <= 1'b0;
            ovr        <= 1'b0;

            // Period/high counters: held at 0 in IDLE, free-running otherwise,
            // reloaded to 1 on every rise (the rise cycle itself is high).
            if (state == S_IDLE) begin
                per_cnt <= rise ? CNT_ONE : '0;
                hi_cnt  <= rise ? CNT_ONE : '0;
            end else if (rise) begin
                per_cnt <= CNT_ONE;
                hi_cnt  <= CNT_ONE;
            end else begin
                per_cnt <= per_inc;
                hi_cnt  <= hi_inc;
            end

            case (state)
                S_IDLE: begin
                    // First edge only arms the measurement.
                    if (rise) begin
                        state <= S_MEASURE;
                    end
                end

                S_MEASURE: begin
                    if (rise) begin
                        p_reg <= per_cnt;
                        rem   <= hi_cnt;
                        quo   <= '0;
                        iter  <= '0;
                        state <= S_DIVIDE;
                    end else if (timeout) begin
                        duty       <= timeout_duty;
                        duty_valid <= 1'b1;
                        per_cnt    <= '0;
                        hi_cnt     <= '0;
                        state      <= S_IDLE;
                    end
                end

                S_DIVIDE: begin
                    // The counters above have already reloaded for this rise;
                    // only the capture is lost.
                    if (rise) begin
                        ovr <= 1'b1;
                    end
                    if (iter != ITER_DONE) begin
                        rem  <= rem_nxt;
                        quo  <= quo_nxt[M-2:0];
                        iter <= iter + ITER_ONE;
                        if (iter == ITER_LAST) begin
                            duty       <= quo_nxt;
                            duty_valid <= 1'b1;
                        end
                    end else if (timeout) begin
                        // Counter saturated while dividing: report it now.
                        duty       <= timeout_duty;
                        duty_valid <= 1'b1;
                        per_cnt    <= '0;
                        hi_cnt     <= '0;
                        state      <= S_IDLE;
                    end else begin
                        // Output cycle: duty_valid is high, back to measuring.
                        state <= S_MEASURE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_demod.sv
module tb_pwm_demod;

    localparam int N    = 14;
    localparam int M    = 12;
    localparam int MAXC = (1 << N) - 1;
`ifdef PWM_DEMOD_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         pwm_in;
    logic [M-1:0] duty;
    logic         duty_valid;
    logic         ovr;

    pwm_demod #(.N(N), .M(M)) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .duty       (duty),
        .duty_valid (duty_valid),
        .ovr        (ovr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Observed and expected events (cycle stamps from cyc, read at negedge)
    int obs_v_cyc[$];
    int obs_v_duty[$];
    int obs_o_cyc[$];
    int exp_v_cyc[$];
    int exp_v_duty[$];
    int exp_o_cyc[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (duty_valid) begin
                obs_v_cyc.push_back(cyc);
                obs_v_duty.push_back(int'(duty));
            end
            if (ovr) obs_o_cyc.push_back(cyc);
        end
    end

    // Reference model: one event per rise, in terms of drive cycles.
    bit m_armed;
    int m_cap_k;
    int m_reload_k;
    int m_reload_h;

    task automatic model_reset();
        m_armed    = 1'b0;
        m_cap_k    = -100000;
        m_reload_k = 0;
        m_reload_h = 0;
    endtask

    task automatic model_rise(input int k, input int h);
        int p_meas;
        if (!m_armed) begin
            m_armed = 1'b1;
        end else if (k - m_cap_k <= M + 1) begin
            exp_o_cyc.push_back(k + 1 + SYNC_LAT);
        end else begin
            p_meas = k - m_reload_k;
            exp_v_cyc.push_back(k + M + 1 + SYNC_LAT);
            exp_v_duty.push_back((m_reload_h * (1 << M)) / p_meas);
            m_cap_k = k;
        end
        m_reload_k = k;
        m_reload_h = h;
    endtask

    task automatic chk_int(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic compare_events(input string tag);
        int n;
        @(posedge clk);
        #1;
        chk_int({tag, ".valid_count"}, obs_v_cyc.size(), exp_v_cyc.size());
        n = (obs_v_cyc.size() < exp_v_cyc.size()) ? obs_v_cyc.size() : exp_v_cyc.size();
        for (int i = 0; i < n; i++) begin
            chk_int($sformatf("%s.valid_cycle[%0d]", tag, i), obs_v_cyc[i], exp_v_cyc[i]);
            chk_int($sformatf("%s.duty[%0d]", tag, i), obs_v_duty[i], exp_v_duty[i]);
        end
        chk_int({tag, ".ovr_count"}, obs_o_cyc.size(), exp_o_cyc.size());
        n = (obs_o_cyc.size() < exp_o_cyc.size()) ? obs_o_cyc.size() : exp_o_cyc.size();
        for (int i = 0; i < n; i++) begin
            chk_int($sformatf("%s.ovr_cycle[%0d]", tag, i), obs_o_cyc[i], exp_o_cyc[i]);
        end
        obs_v_cyc.delete();
        obs_v_duty.delete();
        obs_o_cyc.delete();
        exp_v_cyc.delete();
        exp_v_duty.delete();
        exp_o_cyc.delete();
    endtask

    // First n cycles of a period whose high time is h (rise on cycle 0).
    task automatic drive_cycles(input int h, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) model_rise(cyc, h);
            pwm_in = (i < h);
        end
    endtask

    task automatic drive_period(input int p, input int h);
        drive_cycles(h, p);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pwm_in = 1'b0;
        end
    endtask

    // Events the model predicted at or after the reset point never happen.
    task automatic do_reset();
        int c;
        @(posedge clk);
        #2;
        rst    = 1'b1;
        pwm_in = 1'b0;
        c      = cyc;
        for (int i = exp_v_cyc.size() - 1; i >= 0; i--) begin
            if (exp_v_cyc[i] >= c) begin
                exp_v_cyc.delete(i);
                exp_v_duty.delete(i);
            end
        end
        for (int i = exp_o_cyc.size() - 1; i >= 0; i--) begin
            if (exp_o_cyc[i] >= c) exp_o_cyc.delete(i);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        int k;
        int p;
        int h;

        rst    = 1'b1;
        pwm_in = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_int("reset.duty", int'(duty), 0);
        chk_int("reset.duty_valid", int'(duty_valid), 0);
        chk_int("reset.ovr", int'(ovr), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Period 64, high 16: first rise arms, later rises give 1024.
        repeat (3) drive_period(64, 16);
        idle(M + SYNC_LAT + 6);
        compare_events("p64");
        chk_int("p64.duty_held", int'(duty), 1024);

        // Period 100, high 33: floor(1351.68), no overrun.
        do_reset();
        repeat (5) drive_period(100, 33);
        idle(M + SYNC_LAT + 6);
        compare_events("p100");
        chk_int("p100.duty_held", int'(duty), 1351);

        // Period 10, high 5: every other rise lands in DIVIDE.
        do_reset();
        repeat (9) drive_period(10, 5);
        idle(M + SYNC_LAT + 6);
        compare_events("p10");
        chk_int("p10.duty_held", int'(duty), 2048);

        // Shortest period with no overrun, then one cycle shorter.
        do_reset();
        repeat (5) drive_period(M + 2, 7);
        idle(M + SYNC_LAT + 6);
        compare_events("p14");
        do_reset();
        repeat (5) drive_period(M + 1, 6);
        idle(M + SYNC_LAT + 6);
        compare_events("p13");

        // Reset in the middle of a divide.
        do_reset();
        drive_period(64, 16);
        drive_cycles(16, 6 + SYNC_LAT);
        do_reset();
        #1;
        chk_int("abort.duty", int'(duty), 0);
        idle(30);
        compare_events("abort");
        repeat (3) drive_period(64, 16);
        idle(M + SYNC_LAT + 6);
        compare_events("after_abort");
        chk_int("after_abort.duty_held", int'(duty), 1024);

        // Randomised periods, including ones short enough to overrun.
        do_reset();
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) p = $urandom_range(15, 300);
            else                           p = $urandom_range(2, 30);
            h = $urandom_range(1, p - 1);
            drive_period(p, h);
        end
        idle(M + SYNC_LAT + 6);
        compare_events("random");

        // Timeout with the input held high, then held low.
        do_reset();
        @(negedge clk);
        k = cyc;
        model_rise(k, 0);
        pwm_in = 1'b1;
        exp_v_cyc.push_back(k + MAXC + 1 + SYNC_LAT);
        exp_v_duty.push_back((1 << M) - 1);
        m_armed = 1'b0;
        repeat (MAXC + 20) @(negedge clk);
        compare_events("hold_high");
        chk_int("hold_high.duty_held", int'(duty), (1 << M) - 1);

        idle(5);
        @(negedge clk);
        k = cyc;
        model_rise(k, 1);
        pwm_in = 1'b1;
        @(negedge clk);
        pwm_in = 1'b0;
        exp_v_cyc.push_back(k + MAXC + 1 + SYNC_LAT);
        exp_v_duty.push_back(0);
        m_armed = 1'b0;
        repeat (MAXC + 20) @(negedge clk);
        compare_events("hold_low");
        chk_int("hold_low.duty_held", int'(duty), 0);

        // After a timeout the block is back in IDLE: next rise only arms.
        repeat (3) drive_period(64, 16);
        idle(M + SYNC_LAT + 6);
        compare_events("post_timeout");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
